// File: rtl/mioc_dram_seq_if.sv
// Requester handshake plus DRAM strobe/address-mux bundle for mioc_dram_seq.
interface mioc_dram_seq_if;
    logic       acc_req;
    logic       acc_wr;
    logic       acc_ack;
    logic       ras_n;
    logic       cas_n;
    logic       we_n;
    logic       row_sel;
    logic [6:0] ref_row;
    logic       busy;

    modport master (
        output acc_req, acc_wr,
        input  acc_ack, ras_n, cas_n, we_n, row_sel, ref_row, busy
    );

    modport slave (
        input  acc_req, acc_wr,
        output acc_ack, ras_n, cas_n, we_n, row_sel, ref_row, busy
    );
endinterface

// File: rtl/mioc_dram_seq.sv
// RAS/CAS/precharge DRAM access sequencer with RAS-only refresh.
// Refresh timer, REF state and refresh row counter exist only when MIOC_REFRESH_EN is defined.
module mioc_dram_seq #(
    parameter int unsigned RAS_CYCLES = 2,
    parameter int unsigned CAS_CYCLES = 2,
    parameter int unsigned PRE_CYCLES = 1,
    parameter int unsigned REF_PERIOD = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    mioc_dram_seq_if.slave dram
);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ROW_W   = 7;
    localparam int unsigned REF_LEN = RAS_CYCLES + CAS_CYCLES;

    if (RAS_CYCLES < 1 || RAS_CYCLES > 7) begin : g_bad_ras
        $error("RAS_CYCLES must be 1..7");
    end
    if (CAS_CYCLES < 1 || CAS_CYCLES > 7) begin : g_bad_cas
        $error("CAS_CYCLES must be 1..7");
    end
    if (PRE_CYCLES < 1 || PRE_CYCLES > 7) begin : g_bad_pre
        $error("PRE_CYCLES must be 1..7");
    end
    if (REF_PERIOD < 16 || REF_PERIOD > 1023) begin : g_bad_ref
        $error("REF_PERIOD must be 16..1023");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAS,
        S_CAS,
        S_REF,
        S_PRE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               ras_n_q, ras_n_d;
    logic               cas_n_q, cas_n_d;
    logic               we_n_q, we_n_d;
    logic               row_sel_q, row_sel_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               ref_pend;
    logic [ROW_W-1:0]   ref_row;

    // Next state; strobes are decoded from the next state so they leave flops aligned with it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        wr_d    = wr_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ref_pend) begin
                    state_d = S_REF;
                end else if (dram.acc_req) begin
                    state_d = S_RAS;
                    wr_d    = dram.acc_wr;
                end
            end
            S_RAS: begin
                if (cnt_q == CNT_W'(RAS_CYCLES - 1)) begin
                    state_d = S_CAS;
                    cnt_d   = '0;
                end
            end
            S_CAS: begin
                if (cnt_q == CNT_W'(CAS_CYCLES - 1)) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end
            end
            S_REF: begin
                if (cnt_q == CNT_W'(REF_LEN - 1)) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                end
            end
            S_PRE: begin
                if (cnt_q == CNT_W'(PRE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        ras_n_d   = !((state_d == S_RAS) || (state_d == S_CAS) || (state_d == S_REF));
        cas_n_d   = (state_d != S_CAS);
        we_n_d    = !((state_d == S_CAS) && wr_d);
        row_sel_d = (state_d != S_CAS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            we_n_q    <= 1'b1;
            row_sel_q <= 1'b1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            ras_n_q   <= ras_n_d;
            cas_n_q   <= cas_n_d;
            we_n_q    <= we_n_d;
            row_sel_q <= row_sel_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

`ifdef MIOC_REFRESH_EN
    localparam int unsigned TMR_W = $clog2(REF_PERIOD);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ref_pend_q, ref_pend_d;
    logic [ROW_W-1:0] ref_row_q, ref_row_d;
    logic             tmr_tc;

    // A terminal count wins over the clear so a period ending on the REF entry edge is kept
    always_comb begin
        tmr_tc     = (timer_q == TMR_W'(REF_PERIOD - 1));
        timer_d    = tmr_tc ? '0 : timer_q + TMR_W'(1);
        ref_pend_d = ref_pend_q;
        if ((state_q == S_IDLE) && (state_d == S_REF)) begin
            ref_pend_d = 1'b0;
        end
        if (tmr_tc) begin
            ref_pend_d = 1'b1;
        end
        ref_row_d = ref_row_q;
        if ((state_q == S_REF) && (state_d == S_PRE)) begin
            ref_row_d = ref_row_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            ref_pend_q <= 1'b0;
            ref_row_q  <= '0;
        end else begin
            timer_q    <= timer_d;
            ref_pend_q <= ref_pend_d;
            ref_row_q  <= ref_row_d;
        end
    end

    assign ref_pend = ref_pend_q;
    assign ref_row  = ref_row_q;
`else
    assign ref_pend = 1'b0;
    assign ref_row  = '0;
`endif

    assign dram.acc_ack = ack_q;
    assign dram.ras_n   = ras_n_q;
    assign dram.cas_n   = cas_n_q;
    assign dram.we_n    = we_n_q;
    assign dram.row_sel = row_sel_q;
    assign dram.busy    = busy_q;
    assign dram.ref_row = ref_row;
endmodule

// File: tb/tb_mioc_dram_seq.sv
// Scoreboard bench for mioc_dram_seq: randomized requester, trace-level reference model of each operation.
module tb_mioc_dram_seq;
    localparam int RAS_C  = 2;
    localparam int CAS_C  = 2;
    localparam int PRE_C  = 1;
    localparam int REF_P  = 64;
    localparam int OP_LEN = RAS_C + CAS_C + PRE_C;
    localparam int REF_LAT_MAX = OP_LEN + 1;
`ifdef MIOC_REFRESH_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif
    // Output tuple {ras_n, cas_n, we_n, row_sel, acc_ack}
    localparam logic [4:0] T_IDLE   = 5'b11110;
    localparam logic [4:0] T_ROW    = 5'b01110;
    localparam logic [4:0] T_PRE    = 5'b11110;
    localparam logic [4:0] T_PRE_AK = 5'b11111;

    logic clk;
    logic rst_n;
    mioc_dram_seq_if bus();

    mioc_dram_seq #(
        .RAS_CYCLES(RAS_C),
        .CAS_CYCLES(CAS_C),
        .PRE_CYCLES(PRE_C),
        .REF_PERIOD(REF_P)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .dram (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         exp_q[$];
    bit         mon_en = 1'b0;
    bit         req_at;
    int         e;
    bit         prev_busy;
    bit         in_op;
    bit         op_ref;
    int         op_start;
    logic [4:0] trace[$];
    bit         pend_m;
    int         tc_e;
    logic [6:0] ref_m;
    int         ref_seen;
    int         last_ref;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    // Expected output tuple for cycle i of an access (write flag wr) or a refresh
    function automatic logic [4:0] exp_at(input bit is_ref, input bit wr, input int i);
        if (i < RAS_C + CAS_C) begin
            if (is_ref || i < RAS_C) return T_ROW;
            return {2'b00, ~wr, 2'b00};
        end
        if (!is_ref && i == RAS_C + CAS_C) return T_PRE_AK;
        return T_PRE;
    endfunction

    task automatic start_mon();
        e         = -1;
        prev_busy = 1'b0;
        in_op     = 1'b0;
        pend_m    = 1'b0;
        tc_e      = 0;
        ref_m     = '0;
        ref_seen  = 0;
        last_ref  = 0;
        trace.delete();
        mon_en    = 1'b1;
    endtask

    task automatic finish_op();
        bit wr;
        int diff;
        wr   = 1'b0;
        diff = -1;
        if (op_ref) begin
            ref_m = ref_m + 7'd1;
        end else begin
            chk("access_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) wr = exp_q.pop_front();
        end
        for (int i = 0; i < trace.size() && i < OP_LEN; i++) begin
            if (diff < 0 && trace[i] !== exp_at(op_ref, wr, i)) diff = i;
        end
        checks++;
        if (trace.size() != OP_LEN || diff >= 0) begin
            errors++;
            $display("FAIL op_trace start=%0d ref=%0b wr=%0b len=%0d required_len=%0d first_diff=%0d actual=%b required=%b",
                     op_start, op_ref, wr, trace.size(), OP_LEN, diff,
                     (diff >= 0) ? trace[diff] : 5'b0, (diff >= 0) ? exp_at(op_ref, wr, diff) : 5'b0);
        end
        in_op = 1'b0;
    endtask

    // One sample per cycle, taken on the falling edge after rising edge number e
    task automatic mon_cycle();
        logic [4:0] cur;
        bit         exp_start;
        cur = {bus.ras_n, bus.cas_n, bus.we_n, bus.row_sel, bus.acc_ack};
        e++;
        if (!prev_busy) begin
            exp_start = pend_m || req_at;
            chk("op_start", int'(bus.busy), int'(exp_start));
            if (bus.busy) begin
                in_op    = 1'b1;
                op_ref   = pend_m;
                op_start = e;
                trace.delete();
                if (pend_m) begin
                    chk("ref_latency", int'((e - tc_e) <= REF_LAT_MAX), 1);
                    if (ref_seen > 0) chk("ref_spacing", int'((e - last_ref) <= REF_P + 5), 1);
                    ref_seen++;
                    last_ref = e;
                    pend_m   = 1'b0;
                end
            end
        end
        if (bus.busy && in_op) begin
            trace.push_back(cur);
            if (trace.size() > 40) begin
                chk("op_length_bound", trace.size(), OP_LEN);
                in_op = 1'b0;
            end
        end
        if (!bus.busy) begin
            if (prev_busy && in_op) finish_op();
            chk("idle_outputs", int'(cur), int'(T_IDLE));
            chk("ref_row", int'(bus.ref_row), int'(ref_m));
        end
        if (REF_EN && (e % REF_P) == REF_P - 1 && !pend_m) begin
            pend_m = 1'b1;
            tc_e   = e;
        end
        prev_busy = bus.busy;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            req_at = bus.acc_req;
            @(negedge clk);
            if (mon_en) mon_cycle();
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ras_n"},   int'(bus.ras_n),   1);
        chk({tag, "_cas_n"},   int'(bus.cas_n),   1);
        chk({tag, "_we_n"},    int'(bus.we_n),    1);
        chk({tag, "_row_sel"}, int'(bus.row_sel), 1);
        chk({tag, "_ack"},     int'(bus.acc_ack), 0);
        chk({tag, "_busy"},    int'(bus.busy),    0);
        chk({tag, "_ref_row"}, int'(bus.ref_row), 0);
    endtask

    task automatic issue(input bit wr);
        bus.acc_wr  = wr;
        bus.acc_req = 1'b1;
        exp_q.push_back(wr);
    endtask

    // Hold the request until CAS, then scramble acc_wr (and maybe drop the request) until ack
    task automatic complete(input bit allow_drop);
        int c;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.cas_n) break;
        end
        chk("cas_wait", int'(c < 40), 1);
        if (allow_drop && $urandom_range(0, 3) == 0) bus.acc_req = 1'b0;
        bus.acc_wr = 1'($urandom_range(0, 1));
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.acc_ack) break;
            bus.acc_wr = 1'($urandom_range(0, 1));
        end
        chk("ack_wait", int'(c < 20), 1);
        @(negedge clk);
        bus.acc_req = 1'b0;
    endtask

    task automatic run_accesses(input int n, input int max_gap, input bit allow_drop);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, max_gap);
            repeat (gap) @(negedge clk);
            issue(1'($urandom_range(0, 1)));
            complete(allow_drop);
        end
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c;
        clk         = 1'b0;
        rst_n       = 1'b0;
        bus.acc_req = 1'b0;
        bus.acc_wr  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");

        // Read requested on the very first edge after reset release
        issue(1'b0);
        #2;
        start_mon();
        rst_n = 1'b1;
        complete(1'b0);

        run_accesses(20, 3, 1'b1);
        repeat (3000) @(negedge clk);
        run_accesses(300, 30, 1'b1);
        run_accesses(40, 0, 1'b0);
        drain();

        // Reset pulled during CAS aborts the access with no ack
        mon_en      = 1'b0;
        bus.acc_wr  = 1'b1;
        bus.acc_req = 1'b1;
        for (c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.cas_n) break;
        end
        chk("rst_cas_wait", int'(c < 40), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_cas");
        bus.acc_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_ack", int'(bus.acc_ack), 0);
            chk("rst_hold_busy", int'(bus.busy), 0);
        end
        exp_q.delete();
        #2;
        start_mon();
        rst_n = 1'b1;
        @(negedge clk);
        run_accesses(20, 4, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
